// File: rtl/mult8s_csa_seq_ppg.sv
// Sequential 8x8 signed partial-product generator with a 3:2 carry-save reducer.
// Optional MULT8S_PPG_ZERO_SKIP_EN: zero operands bypass RUN and finish with all-zero rows.
module mult8s_csa_seq_ppg (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] in_a,
  input  logic signed [7:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [14:0]       pp_s,
  output logic [14:0]       pp_c,
  output logic              pp_hi
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [15:0]        s_q;
  logic [15:0]        c_q;
  logic signed [7:0]  a_q;
  logic signed [7:0]  b_q;
  logic [2:0]         cnt;
  logic [15:0]        row_x;
  logic [15:0]        s_nxt;
  logic [15:0]        c_nxt;

  // Row cnt of the signed array; the sign row is inverted and its +1 lives in the initial C.
  function automatic logic [15:0] pp_row(input logic signed [7:0] a,
                                         input logic              b_bit,
                                         input logic [2:0]        idx);
    logic [15:0] p;
    p = {{8{a[7]}}, a} & {16{b_bit}};
    p = p << idx;
    return (idx == 3'd7) ? ~p : p;
  endfunction

  function automatic logic [15:0] csa_sum(input logic [15:0] s, input logic [15:0] c,
                                          input logic [15:0] x);
    return s ^ c ^ x;
  endfunction

  function automatic logic [15:0] csa_carry(input logic [15:0] s, input logic [15:0] c,
                                            input logic [15:0] x);
    return ((s & c) | (s & x) | (c & x)) << 1;
  endfunction

  always_comb begin
    row_x = pp_row(a_q, b_q[cnt], cnt);
    s_nxt = csa_sum(s_q, c_q, row_x);
    c_nxt = csa_carry(s_q, c_q, row_x);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s_q       <= '0;
      c_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= in_b;
            cnt      <= '0;
            in_ready <= 1'b0;
`ifdef MULT8S_PPG_ZERO_SKIP_EN
            if (in_a == 8'sd0 || in_b == 8'sd0) begin
              s_q       <= '0;
              c_q       <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              s_q   <= '0;
              c_q   <= 16'h0001;
              state <= RUN;
            end
`else
            s_q   <= '0;
            c_q   <= 16'h0001;
            state <= RUN;
`endif
          end
        end
        RUN: begin
          s_q <= s_nxt;
          c_q <= c_nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign pp_s  = s_q[14:0];
  assign pp_c  = c_q[14:0];
  assign pp_hi = s_q[15] ^ c_q[15];

endmodule

// File: tb/tb_mult8s_csa_seq_ppg.sv
// Scoreboard bench for mult8s_csa_seq_ppg: products pushed at issue, popped at completion.
module tb_mult8s_csa_seq_ppg;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_a;
  logic signed [7:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [14:0]       pp_s;
  logic [14:0]       pp_c;
  logic              pp_hi;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  mult8s_csa_seq_ppg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .pp_s(pp_s), .pp_c(pp_c), .pp_hi(pp_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  function automatic logic [15:0] ref_prod(input logic signed [7:0] a, input logic signed [7:0] b);
    int p;
    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  // Reference 15-bit adder plus the parity bit, as the downstream stage would form it.
  function automatic logic [15:0] adder_out();
    logic [15:0] t;
    t = {1'b0, pp_s} + {1'b0, pp_c};
    return {pp_hi ^ t[15], t[14:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic signed [7:0] a, input logic signed [7:0] b);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    exp_q.push_back(ref_prod(a, b));
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    step(); step();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++;
    if ({pp_s, pp_c, pp_hi} !== 31'd0)
      $display("FAIL reset_outputs got s=%h c=%h hi=%b exp 0", pp_s, pp_c, pp_hi);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] prod, e;
    issue(8'sd3, 8'sd5);
    wait_out(lat);
    n_checks++;
    if (lat !== 8) $display("FAIL basic_latency got %0d exp 8", lat); else n_pass++;
    prod = adder_out();
    e = exp_q.pop_front();
    n_checks++;
    if (prod[14:0] !== 15'h000F) $display("FAIL basic_sum got %h exp 000f", prod[14:0]); else n_pass++;
    n_checks++;
    if (prod[15] !== 1'b0) $display("FAIL basic_bit15 got %b exp 0", prod[15]); else n_pass++;
    n_checks++;
    if (prod !== e) $display("FAIL basic_sb got %h exp %h", prod, e); else n_pass++;
    finish_op();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL basic_in_ready got %b exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_corner(input logic signed [7:0] a, input logic signed [7:0] b,
                             input logic [15:0] want);
    int lat;
    logic [15:0] prod, e;
    issue(a, b);
    wait_out(lat);
    prod = adder_out();
    e = exp_q.pop_front();
    n_checks++;
    if (lat !== 8 || prod !== want)
      $display("FAIL corner_%0d_x_%0d got %h lat %0d exp %h lat 8", a, b, prod, lat, want);
    else n_pass++;
    n_checks++;
    if (prod !== e) $display("FAIL corner_sb got %h exp %h", prod, e); else n_pass++;
    finish_op();
  endtask

  task automatic test_random(input int n);
    int lat;
    logic [15:0] prod, e;
    logic signed [7:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      issue(a, b);
      wait_out(lat);
      prod = adder_out();
      e = exp_q.pop_front();
      n_checks++;
      if (lat !== 8 || prod !== e)
        $display("FAIL random_%0d_x_%0d got %h lat %0d exp %h lat 8", a, b, prod, lat, e);
      else n_pass++;
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [30:0] held;
    logic [15:0] prod, e;
    issue(8'sd7, -8'sd9);
    wait_out(lat);
    held = {pp_s, pp_c, pp_hi};
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({pp_s, pp_c, pp_hi} !== held || in_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL bp_hold_%0d got %h rdy %b vld %b exp %h rdy 0 vld 1",
                 i, {pp_s, pp_c, pp_hi}, in_ready, out_valid, held);
      else n_pass++;
    end
    prod = adder_out();
    e = exp_q.pop_front();
    n_checks++;
    if (prod !== e) $display("FAIL bp_result got %h exp %h", prod, e); else n_pass++;
    finish_op();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got rdy %b vld %b exp rdy 1 vld 0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] prod, e;
    issue(-8'sd77, 8'sd100);
    step(); step(); step();
    rst = 1'b1;
    #1;
    void'(exp_q.pop_front());
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {pp_s, pp_c, pp_hi} !== 31'd0)
      $display("FAIL rst_mid got vld %b rdy %b s=%h c=%h hi=%b exp vld 0 rdy 1 all 0",
               out_valid, in_ready, pp_s, pp_c, pp_hi);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    issue(-8'sd77, 8'sd100);
    wait_out(lat);
    prod = adder_out();
    e = exp_q.pop_front();
    n_checks++;
    if (lat !== 8 || prod !== e)
      $display("FAIL rst_mid_next got %h lat %0d exp %h lat 8", prod, lat, e);
    else n_pass++;
    finish_op();
  endtask

  task automatic test_zero();
    int lat;
    logic [15:0] prod, e;
    issue(8'sd0, -8'sd77);
    wait_out(lat);
    prod = adder_out();
    e = exp_q.pop_front();
`ifdef MULT8S_PPG_ZERO_SKIP_EN
    // Skip path: out_valid is already visible right after the acceptance edge.
    n_checks++;
    if (lat !== 0) $display("FAIL zero_latency got %0d exp 0", lat); else n_pass++;
    n_checks++;
    if ({pp_s, pp_c, pp_hi} !== 31'd0)
      $display("FAIL zero_outputs got s=%h c=%h hi=%b exp 0", pp_s, pp_c, pp_hi);
    else n_pass++;
`else
    n_checks++;
    if (lat !== 8) $display("FAIL zero_latency got %0d exp 8", lat); else n_pass++;
    n_checks++;
    if (16'({1'b0, pp_s} + {1'b0, pp_c}) + {pp_hi, 15'd0} !== 16'd0)
      $display("FAIL zero_rows got s=%h c=%h hi=%b exp sum 0", pp_s, pp_c, pp_hi);
    else n_pass++;
`endif
    n_checks++;
    if (prod !== e) $display("FAIL zero_sb got %h exp %h", prod, e); else n_pass++;
    finish_op();
  endtask

  task automatic test_back_to_back();
    int acc[4];
    int issued = 0;
    int done = 0;
    int budget = 0;
    logic [15:0] prod, e;
    logic signed [7:0] a, b;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (done < 4 && budget < 80) begin
      if (out_valid) begin
        prod = adder_out();
        e = exp_q.pop_front();
        n_checks++;
        if (prod !== e) $display("FAIL b2b_result_%0d got %h exp %h", done, prod, e); else n_pass++;
        done++;
      end
      if (in_ready && issued < 4) begin
        a = 8'($urandom);
        b = 8'($urandom);
        in_a = a;
        in_b = b;
        exp_q.push_back(ref_prod(a, b));
        acc[issued] = cyc;
        issued++;
      end
      step();
      budget++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (done !== 4) $display("FAIL b2b_timeout got %0d results exp 4", done); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (acc[k+1] - acc[k] !== 10)
        $display("FAIL b2b_interval_%0d got %0d exp 10", k, acc[k+1] - acc[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corner(-8'sd128, -8'sd128, 16'h4000);
    test_corner(-8'sd1, 8'sd1, 16'hFFFF);
    test_corner(8'sd127, -8'sd128, 16'hC080);
    test_corner(8'sd127, 8'sd127, 16'h3F01);
    test_random(300);
    test_backpressure();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
